// File: rtl/single_port_ram_param.sv
// Parametrised single-port synchronous RAM with byte enables, registered read + valid strobe,
// selectable read-during-write behaviour and a post-reset clear engine.
module single_port_ram_param #(
  parameter int                DATA_W     = 8,
  parameter int                DEPTH      = 8,
  parameter int                ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int                RD_MODE    = 0,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   data,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic                re,
  output logic [DATA_W-1:0]   q,
  output logic                q_valid,
  output logic                ready,
  output logic                err
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] q_q;
  logic              q_valid_q;
  logic              ready_q;
  logic              err_q;

  // NOTE: the array has no reset; the clear engine initialises it after every reset instead.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              in_range;
  logic              accept_wr;
  logic              accept_rd;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] rd_word;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    in_range  = int'(addr) < DEPTH;
    accept_wr = ready_q & we & in_range;
    accept_rd = ready_q & re;
    old_word  = in_range ? mem_q[addr] : '0;

    merged_word = old_word;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) merged_word[8*b +: 8] = data[8*b +: 8];
    end

    if (!in_range)                      rd_word = '0;
    else if (RD_MODE == 1 && accept_wr) rd_word = merged_word;
    else                                rd_word = old_word;

    // Clear engine owns the write port until RUN; nothing is written while rst is held.
    wr_en_d   = 1'b0;
    wr_addr_d = addr;
    wr_data_d = merged_word;
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q;
        wr_data_d = INIT_VALUE;
      end else begin
        wr_en_d = accept_wr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_d) mem_q[wr_addr_d] <= wr_data_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      ptr_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          q_valid_q <= 1'b0;
          err_q     <= 1'b0;
          ptr_q     <= ptr_q + 1'b1;
          if (ptr_q == LAST_PTR) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          q_valid_q <= accept_rd;
          err_q     <= (we | re) & ~in_range;
          if (accept_rd) q_q <= rd_word;
        end
      endcase
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign ready   = ready_q;
  assign err     = err_q;

endmodule

// File: tb/tb_single_port_ram_param.sv
// Directed bench for single_port_ram_param: three instances cover 8x8 read-first,
// 32-bit write-first, and a non-power-of-two depth with a non-zero clear value.
module tb_single_port_ram_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Instance A: DATA_W=8, DEPTH=8, RD_MODE=0, INIT=0
  logic       a_rst = 1'b1, a_we = 1'b0, a_re = 1'b0, a_be = 1'b0;
  logic [2:0] a_addr = '0;
  logic [7:0] a_data = '0, a_q;
  logic       a_qv, a_rdy, a_err;

  // Instance B: DATA_W=32, DEPTH=8, RD_MODE=1, INIT=0
  logic        b_rst = 1'b1, b_we = 1'b0, b_re = 1'b0;
  logic [3:0]  b_be = '0;
  logic [2:0]  b_addr = '0;
  logic [31:0] b_data = '0, b_q;
  logic        b_qv, b_rdy, b_err;

  // Instance C: DATA_W=8, DEPTH=6, RD_MODE=0, INIT=0xA5
  logic       c_rst = 1'b1, c_we = 1'b0, c_re = 1'b0, c_be = 1'b0;
  logic [2:0] c_addr = '0;
  logic [7:0] c_data = '0, c_q;
  logic       c_qv, c_rdy, c_err;

  single_port_ram_param #(.DATA_W(8), .DEPTH(8), .RD_MODE(0), .INIT_VALUE(8'h00)) u_a (
    .clk(clk), .rst(a_rst), .data(a_data), .addr(a_addr), .we(a_we), .be(a_be), .re(a_re),
    .q(a_q), .q_valid(a_qv), .ready(a_rdy), .err(a_err));

  single_port_ram_param #(.DATA_W(32), .DEPTH(8), .RD_MODE(1), .INIT_VALUE(32'h0)) u_b (
    .clk(clk), .rst(b_rst), .data(b_data), .addr(b_addr), .we(b_we), .be(b_be), .re(b_re),
    .q(b_q), .q_valid(b_qv), .ready(b_rdy), .err(b_err));

  single_port_ram_param #(.DATA_W(8), .DEPTH(6), .RD_MODE(0), .INIT_VALUE(8'hA5)) u_c (
    .clk(clk), .rst(c_rst), .data(c_data), .addr(c_addr), .we(c_we), .be(c_be), .re(c_re),
    .q(c_q), .q_valid(c_qv), .ready(c_rdy), .err(c_err));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All tasks are entered at posedge+1 and return at the next posedge+1, with outputs settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_op(input logic w, input logic r, input logic [2:0] ad,
                      input logic [7:0] d, input logic bte);
    a_we = w; a_re = r; a_addr = ad; a_data = d; a_be = bte;
    tick();
    a_we = 1'b0; a_re = 1'b0;
  endtask

  task automatic b_op(input logic w, input logic r, input logic [2:0] ad,
                      input logic [31:0] d, input logic [3:0] bte);
    b_we = w; b_re = r; b_addr = ad; b_data = d; b_be = bte;
    tick();
    b_we = 1'b0; b_re = 1'b0;
  endtask

  task automatic c_op(input logic w, input logic r, input logic [2:0] ad,
                      input logic [7:0] d, input logic bte);
    c_we = w; c_re = r; c_addr = ad; c_data = d; c_be = bte;
    tick();
    c_we = 1'b0; c_re = 1'b0;
  endtask

  initial begin
    // Reset: two cycles high
    tick();
    tick();
    check("rst_a_q",     32'(a_q),   32'h0);
    check("rst_a_qv",    32'(a_qv),  32'h0);
    check("rst_a_err",   32'(a_err), 32'h0);
    check("rst_a_ready", 32'(a_rdy), 32'h0);
    check("rst_b_ready", 32'(b_rdy), 32'h0);
    check("rst_c_ready", 32'(c_rdy), 32'h0);

    // Clear engine: A ready after exactly 8 cycles, C (DEPTH=6) after 6
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("clr_a_ready_%0d", k), 32'(a_rdy), (k == 8) ? 32'h1 : 32'h0);
      check($sformatf("clr_c_ready_%0d", k), 32'(c_rdy), (k >= 6) ? 32'h1 : 32'h0);
    end
    check("clr_b_ready", 32'(b_rdy), 32'h1);

    // A: all words cleared to zero, back-to-back reads
    a_op(1'b0, 1'b1, 3'd7, 8'h00, 1'b1);
    check("a_pre_qv", 32'(a_qv), 32'h1);
    for (int i = 0; i < 8; i++) begin
      a_op(1'b0, 1'b1, 3'(i), 8'h00, 1'b0);
      check($sformatf("a_clr_q_%0d", i),  32'(a_q),  32'h0);
      check($sformatf("a_clr_qv_%0d", i), 32'(a_qv), 32'h1);
    end

    // A: write 0x01..0x08, then read back
    for (int i = 0; i < 8; i++) begin
      a_op(1'b1, 1'b0, 3'(i), 8'(i + 1), 1'b1);
      check($sformatf("a_wr_qv_%0d", i), 32'(a_qv), 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      a_op(1'b0, 1'b1, 3'(i), 8'h00, 1'b0);
      check($sformatf("a_rd_q_%0d", i),  32'(a_q),  32'(i + 1));
      check($sformatf("a_rd_qv_%0d", i), 32'(a_qv), 32'h1);
    end
    a_op(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    check("a_idle_qv", 32'(a_qv), 32'h0);
    check("a_idle_q_hold", 32'(a_q), 32'h08);

    // A: read-first collision, then be=0 no-op write
    a_op(1'b1, 1'b1, 3'd3, 8'h07, 1'b1);
    check("a_rfirst_q", 32'(a_q), 32'h04);
    a_op(1'b0, 1'b1, 3'd3, 8'h00, 1'b0);
    check("a_rfirst_after", 32'(a_q), 32'h07);
    a_op(1'b1, 1'b0, 3'd5, 8'hFF, 1'b0);
    a_op(1'b0, 1'b1, 3'd5, 8'h00, 1'b0);
    check("a_be0_noop", 32'(a_q), 32'h06);

    // B: byte-enable merge, write-first collisions
    b_op(1'b1, 1'b0, 3'd2, 32'hAABBCCDD, 4'hF);
    b_op(1'b1, 1'b0, 3'd2, 32'h11223344, 4'b0010);
    b_op(1'b0, 1'b1, 3'd2, 32'h0, 4'h0);
    check("b_be_merge", b_q, 32'hAABB33DD);
    b_op(1'b1, 1'b0, 3'd3, 32'h00000004, 4'hF);
    b_op(1'b1, 1'b1, 3'd3, 32'h00000007, 4'hF);
    check("b_wfirst_q",  b_q, 32'h00000007);
    check("b_wfirst_qv", 32'(b_qv), 32'h1);
    b_op(1'b1, 1'b1, 3'd2, 32'h00000099, 4'b0001);
    check("b_wfirst_partial", b_q, 32'hAABB3399);
    b_op(1'b0, 1'b1, 3'd2, 32'h0, 4'h0);
    check("b_partial_stored", b_q, 32'hAABB3399);

    // C: clear value, out-of-range accesses, boundary word
    for (int i = 0; i < 6; i++) begin
      c_op(1'b0, 1'b1, 3'(i), 8'h00, 1'b0);
      check($sformatf("c_init_%0d", i), 32'(c_q), 32'hA5);
    end
    c_op(1'b1, 1'b0, 3'd7, 8'h33, 1'b1);
    check("c_oor_wr_err", 32'(c_err), 32'h1);
    check("c_oor_wr_qv",  32'(c_qv),  32'h0);
    c_op(1'b0, 1'b1, 3'd7, 8'h00, 1'b0);
    check("c_oor_rd_err", 32'(c_err), 32'h1);
    check("c_oor_rd_qv",  32'(c_qv),  32'h1);
    check("c_oor_rd_q",   32'(c_q),   32'h0);
    c_op(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    check("c_err_pulse", 32'(c_err), 32'h0);
    c_op(1'b0, 1'b1, 3'd6, 8'h00, 1'b0);
    check("c_oor6_err", 32'(c_err), 32'h1);
    c_op(1'b1, 1'b0, 3'd5, 8'h12, 1'b1);
    check("c_last_wr_err", 32'(c_err), 32'h0);
    c_op(1'b0, 1'b1, 3'd5, 8'h00, 1'b0);
    check("c_last_rd", 32'(c_q), 32'h12);
    for (int i = 0; i < 5; i++) begin
      c_op(1'b0, 1'b1, 3'(i), 8'h00, 1'b0);
      check($sformatf("c_untouched_%0d", i), 32'(c_q), 32'hA5);
    end

    // A: reset pulse at clear cycle 4, commands ignored while clearing
    a_rst = 1'b1;
    a_op(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    check("a_rst2_ready", 32'(a_rdy), 32'h0);
    a_rst = 1'b0;
    for (int k = 0; k < 4; k++) a_op(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    check("a_mid_ready", 32'(a_rdy), 32'h0);
    a_rst = 1'b1;
    a_op(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    a_rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) begin
        a_op(1'b1, 1'b1, 3'd2, 8'hFF, 1'b1);
        check("a_ign_qv",  32'(a_qv),  32'h0);
        check("a_ign_err", 32'(a_err), 32'h0);
      end else begin
        a_op(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
      end
      check($sformatf("a_reclr_ready_%0d", k), 32'(a_rdy), (k == 8) ? 32'h1 : 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      a_op(1'b0, 1'b1, 3'(i), 8'h00, 1'b0);
      check($sformatf("a_reclr_q_%0d", i), 32'(a_q), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
